decode_stage: RTL and testbench

- Registered MIPS decode stage between IF and EX.
- Decodes the instruction into a one-hot instruction vector and a type vector, extracts register fields, the destination and the extended immediate.
- Carries a valid/ready handshake, flush, and load-use hazard bubble insertion.
- Parametrised successor of the combinational decoder; EXT_ISA=1 enables the extended instruction set.

---
 rtl/decode_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Registered MIPS decode stage between IF and EX. Produces a
//            one-hot instruction ID, a type vector, register fields, the
//            write destination and the extended immediate, with a
//            valid/ready handshake, flush and load-use bubble insertion.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int  EXT_ISA   = 0,
    parameter int  PC_WIDTH  = 32,
    localparam int NUM_INSTR = 22 + 7 * EXT_ISA
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [PC_WIDTH-1:0]  in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_INSTR-1:0] out_instr_tb,
    output logic [4:0]           out_type_tb,
    output logic [4:0]           out_rs,
    output logic [4:0]           out_rt,
    output logic [4:0]           out_dst,
    output logic [4:0]           out_shamt,
    output logic [31:0]          out_imm,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic                 hazard_stall
);

    // One-hot positions of the base instruction set
    localparam int c_ID_ADD  = 0,  c_ID_SUB  = 1,  c_ID_AND  = 2,  c_ID_OR   = 3;
    localparam int c_ID_XOR  = 4,  c_ID_NOR  = 5,  c_ID_SLT  = 6,  c_ID_JR   = 7;
    localparam int c_ID_SLL  = 8,  c_ID_SRL  = 9,  c_ID_SRA  = 10, c_ID_SW   = 11;
    localparam int c_ID_LW   = 12, c_ID_ADDI = 13, c_ID_ANDI = 14, c_ID_ORI  = 15;
    localparam int c_ID_XORI = 16, c_ID_SLTI = 17, c_ID_BEQ  = 18, c_ID_BNE  = 19;
    localparam int c_ID_JMP  = 20, c_ID_JAL  = 21;

    logic [5:0]           w_op;
    logic [5:0]           w_fn;
    logic [21:0]          w_base;
    logic [6:0]           w_ext_raw;
    logic [6:0]           w_ext;
    logic [NUM_INSTR-1:0] w_instr_d;
    logic                 w_lui;
    logic                 w_ext_r;
    logic                 w_rd_dst;
    logic                 w_irtype;
    logic                 w_reads_rs;
    logic                 w_reads_rt;
    logic                 w_hazard;
    logic                 w_load;
    logic [4:0]           w_type_d;
    logic [4:0]           w_dst_d;
    logic [31:0]          w_imm_d;

    logic                 valid_q;
    logic [NUM_INSTR-1:0] instr_q;
    logic [4:0]           type_q;
    logic [4:0]           rs_q;
    logic [4:0]           rt_q;
    logic [4:0]           dst_q;
    logic [4:0]           shamt_q;
    logic [31:0]          imm_q;
    logic [PC_WIDTH-1:0]  pc_q;

    assign w_op = in_instr[31:26];
    assign w_fn = in_instr[5:0];

    // Base ISA one-hot: funct selects within SPECIAL (opcode 0), else opcode
    always_comb begin
        w_base = '0;
        if (w_op == 6'h00) begin
            case (w_fn)
                6'h20:   w_base[c_ID_ADD] = 1'b1;
                6'h22:   w_base[c_ID_SUB] = 1'b1;
                6'h24:   w_base[c_ID_AND] = 1'b1;
                6'h25:   w_base[c_ID_OR]  = 1'b1;
                6'h26:   w_base[c_ID_XOR] = 1'b1;
                6'h27:   w_base[c_ID_NOR] = 1'b1;
                6'h2A:   w_base[c_ID_SLT] = 1'b1;
                6'h08:   w_base[c_ID_JR]  = 1'b1;
                6'h00:   w_base[c_ID_SLL] = 1'b1;
                6'h02:   w_base[c_ID_SRL] = 1'b1;
                6'h03:   w_base[c_ID_SRA] = 1'b1;
                default: ;
            endcase
        end else begin
            case (w_op)
                6'h2B:   w_base[c_ID_SW]   = 1'b1;
                6'h23:   w_base[c_ID_LW]   = 1'b1;
                6'h08:   w_base[c_ID_ADDI] = 1'b1;
                6'h0C:   w_base[c_ID_ANDI] = 1'b1;
                6'h0D:   w_base[c_ID_ORI]  = 1'b1;
                6'h0E:   w_base[c_ID_XORI] = 1'b1;
                6'h0A:   w_base[c_ID_SLTI] = 1'b1;
                6'h04:   w_base[c_ID_BEQ]  = 1'b1;
                6'h05:   w_base[c_ID_BNE]  = 1'b1;
                6'h02:   w_base[c_ID_JMP]  = 1'b1;
                6'h03:   w_base[c_ID_JAL]  = 1'b1;
                default: ;
            endcase
        end
    end

    // Extended ISA one-hot {LUI, SRAV, SRLV, SLLV, SLTU, SUBU, ADDU}
    always_comb begin
        w_ext_raw = '0;
        if (w_op == 6'h00) begin
            case (w_fn)
                6'h21:   w_ext_raw[0] = 1'b1;
                6'h23:   w_ext_raw[1] = 1'b1;
                6'h2B:   w_ext_raw[2] = 1'b1;
                6'h04:   w_ext_raw[3] = 1'b1;
                6'h06:   w_ext_raw[4] = 1'b1;
                6'h07:   w_ext_raw[5] = 1'b1;
                default: ;
            endcase
        end else if (w_op == 6'h0F) begin
            w_ext_raw[6] = 1'b1;
        end
    end

    // Without the extension these encodings decode as illegal
    assign w_ext   = (EXT_ISA != 0) ? w_ext_raw : 7'd0;
    assign w_lui   = w_ext[6];
    assign w_ext_r = |w_ext[5:0];

    generate
        if (EXT_ISA != 0) begin : g_ext
            assign w_instr_d = {w_ext, w_base};
        end else begin : g_base
            assign w_instr_d = w_base;
        end
    endgenerate

    // Legal R-type ops that write rd (every one except JR)
    assign w_rd_dst = (|w_base[c_ID_SLT:c_ID_ADD]) | (|w_base[c_ID_SRA:c_ID_SLL]) | w_ext_r;
    assign w_irtype = (|w_base[c_ID_SLTI:c_ID_ADDI]) | w_lui;

    assign w_type_d = {~(|w_instr_d),
                       w_base[c_ID_LW] | w_base[c_ID_SW],
                       w_base[c_ID_BEQ] | w_base[c_ID_BNE] | w_base[c_ID_JMP] |
                       w_base[c_ID_JAL] | w_base[c_ID_JR],
                       w_irtype,
                       (w_op == 6'h00)};

    // Immediate extension chosen by instruction class
    always_comb begin
        w_imm_d = 32'h0;
        if (w_base[c_ID_ADDI] | w_base[c_ID_SLTI] | w_base[c_ID_LW] | w_base[c_ID_SW] |
            w_base[c_ID_BEQ]  | w_base[c_ID_BNE]) begin
            w_imm_d = {{16{in_instr[15]}}, in_instr[15:0]};
        end else if (w_base[c_ID_ANDI] | w_base[c_ID_ORI] | w_base[c_ID_XORI]) begin
            w_imm_d = {16'h0, in_instr[15:0]};
        end else if (w_lui) begin
            w_imm_d = {in_instr[15:0], 16'h0};
        end else if (w_base[c_ID_JMP] | w_base[c_ID_JAL]) begin
            w_imm_d = {4'b0, in_instr[25:0], 2'b00};
        end
    end

    // Write destination; 0 means no register write
    always_comb begin
        w_dst_d = 5'd0;
        if (w_rd_dst) begin
            w_dst_d = in_instr[15:11];
        end else if (w_irtype | w_base[c_ID_LW]) begin
            w_dst_d = in_instr[20:16];
        end else if (w_base[c_ID_JAL]) begin
            w_dst_d = 5'd31;
        end
    end

    // Source-register usage of the incoming instruction (illegal reads nothing)
    assign w_reads_rs = (|w_base[c_ID_JR:c_ID_ADD]) | w_ext_r | (|w_base[c_ID_SLTI:c_ID_ADDI]) |
                        w_base[c_ID_LW] | w_base[c_ID_SW] | w_base[c_ID_BEQ] | w_base[c_ID_BNE];
    assign w_reads_rt = w_rd_dst | w_base[c_ID_SW] | w_base[c_ID_BEQ] | w_base[c_ID_BNE];

    // A held LW whose result the incoming instruction needs forces one bubble
    assign w_hazard = valid_q && instr_q[c_ID_LW] && (dst_q != 5'd0) && in_valid &&
                      ((w_reads_rs && (in_instr[25:21] == dst_q)) ||
                       (w_reads_rt && (in_instr[20:16] == dst_q)));

    assign in_ready     = flush || ((!valid_q || out_ready) && !w_hazard);
    assign hazard_stall = w_hazard && !flush;
    assign w_load       = in_valid && in_ready && !flush;

    // Output bundle: flush/drain/bubble empties, handshake loads, back-pressure holds
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            type_q  <= 5'd0;
            rs_q    <= 5'd0;
            rt_q    <= 5'd0;
            dst_q   <= 5'd0;
            shamt_q <= 5'd0;
            imm_q   <= 32'h0;
            pc_q    <= '0;
        end else if (w_load) begin
            valid_q <= 1'b1;
            instr_q <= w_instr_d;
            type_q  <= w_type_d;
            rs_q    <= in_instr[25:21];
            rt_q    <= in_instr[20:16];
            dst_q   <= w_dst_d;
            shamt_q <= in_instr[10:6];
            imm_q   <= w_imm_d;
            pc_q    <= in_pc;
        end else if (flush || !valid_q || out_ready) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            type_q  <= 5'd0;
            dst_q   <= 5'd0;
        end
    end

    assign out_valid    = valid_q;
    assign out_instr_tb = instr_q;
    assign out_type_tb  = type_q;
    assign out_rs       = rs_q;
    assign out_rt       = rt_q;
    assign out_dst      = dst_q;
    assign out_shamt    = shamt_q;
    assign out_imm      = imm_q;
    assign out_pc       = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Self-checking bench for decode_stage. Two instances (base and
//            extended ISA) share stimulus; a table-driven decoder and a
//            transaction queue supply the expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    localparam int PCW = 32;

    // Opcode (I/J ops) or funct (R ops) per instruction ID, IDs 0..28
    localparam int CODE [29] = '{32, 34, 36, 37, 38, 39, 42, 8, 0, 2, 3,
                                 43, 35, 8, 12, 13, 14, 10, 4, 5, 2, 3,
                                 33, 35, 43, 4, 6, 7, 15};

    typedef struct packed {
        logic [28:0] id;
        logic [4:0]  typ;
        logic [4:0]  dst;
        logic [31:0] imm;
        logic        rrs;
        logic        rrt;
    } dec_t;

    typedef struct packed {
        dec_t        d;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  sh;
        logic [31:0] pc;
    } bun_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, flush, in_valid, out_ready;
    logic [31:0]    in_instr;
    logic [PCW-1:0] in_pc;

    logic           a_in_ready, a_out_valid, a_hazard_stall;
    logic [21:0]    a_out_instr_tb;
    logic [4:0]     a_out_type_tb, a_out_rs, a_out_rt, a_out_dst, a_out_shamt;
    logic [31:0]    a_out_imm;
    logic [PCW-1:0] a_out_pc;

    logic           b_in_ready, b_out_valid, b_hazard_stall;
    logic [28:0]    b_out_instr_tb;
    logic [4:0]     b_out_type_tb, b_out_rs, b_out_rt, b_out_dst, b_out_shamt;
    logic [31:0]    b_out_imm;
    logic [PCW-1:0] b_out_pc;

    int n_cmp = 0;
    int n_err = 0;

    decode_stage #(.EXT_ISA(0), .PC_WIDTH(PCW)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_instr_tb(a_out_instr_tb), .out_type_tb(a_out_type_tb), .out_rs(a_out_rs),
        .out_rt(a_out_rt), .out_dst(a_out_dst), .out_shamt(a_out_shamt), .out_imm(a_out_imm),
        .out_pc(a_out_pc), .hazard_stall(a_hazard_stall)
    );

    decode_stage #(.EXT_ISA(1), .PC_WIDTH(PCW)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_instr_tb(b_out_instr_tb), .out_type_tb(b_out_type_tb), .out_rs(b_out_rs),
        .out_rt(b_out_rt), .out_dst(b_out_dst), .out_shamt(b_out_shamt), .out_imm(b_out_imm),
        .out_pc(b_out_pc), .hazard_stall(b_hazard_stall)
    );

    function automatic bit is_r(input int k);
        return (k <= 10) || (k >= 22 && k <= 27);
    endfunction

    // Reference decoder: table lookup, then class membership by instruction ID
    function automatic dec_t ref_dec(input logic [31:0] w, input bit ext);
        dec_t d;
        int   id;
        bit   rop, irop;
        d  = '0;
        id = -1;
        for (int k = 0; k < 29; k++) begin
            if (k < 22 || ext) begin
                if (is_r(k) && w[31:26] == 6'd0 && int'(w[5:0]) == CODE[k]) id = k;
                if (!is_r(k) && int'(w[31:26]) == CODE[k]) id = k;
            end
        end
        if (id >= 0) d.id[id] = 1'b1;
        rop  = (id >= 0) && is_r(id);
        irop = id inside {13, 14, 15, 16, 17, 28};
        d.typ = {id < 0, id inside {11, 12}, id inside {7, 18, 19, 20, 21}, irop, w[31:26] == 6'd0};
        if (id inside {11, 12, 13, 17, 18, 19})      d.imm = {{16{w[15]}}, w[15:0]};
        else if (id inside {14, 15, 16})            d.imm = {16'h0, w[15:0]};
        else if (id == 28)                          d.imm = {w[15:0], 16'h0};
        else if (id inside {20, 21})                d.imm = {4'b0, w[25:0], 2'b00};
        if (rop && id != 7)                         d.dst = w[15:11];
        else if (irop || id == 12)                  d.dst = w[20:16];
        else if (id == 21)                          d.dst = 5'd31;
        d.rrs = (rop && !(id inside {8, 9, 10})) || (irop && id != 28) || (id inside {11, 12, 18, 19});
        d.rrt = (rop && id != 7) || (id inside {11, 18, 19});
        return d;
    endfunction

    // Random instruction biased toward legal ops on registers 0..3
    function automatic logic [31:0] gen_instr();
        int k;
        logic [4:0] rs, rt, rd;
        if ($urandom_range(0, 5) == 0) return $urandom();
        k  = $urandom_range(0, 28);
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        if (is_r(k)) return {6'h0, rs, rt, rd, 5'($urandom_range(0, 31)), 6'(CODE[k])};
        return {6'(CODE[k]), rs, rt, 16'($urandom())};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [PCW-1:0] pc,
                         input logic rdy, input logic fl, input logic rs);
        @(posedge clk);
        #1;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl; reset = rs;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 1, 0, 1);
        n_cmp++;
        if ({b_out_valid, b_out_instr_tb, b_out_type_tb, b_out_rs, b_out_rt, b_out_dst, b_out_shamt,
             b_out_imm, b_out_pc, b_hazard_stall, b_in_ready} !== {1'b0, 118'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_ext: got valid=%b instr=%h dst=%0d imm=%h stall=%b rdy=%b, want all 0 and rdy=1",
                     b_out_valid, b_out_instr_tb, b_out_dst, b_out_imm, b_hazard_stall, b_in_ready);
        end
        n_cmp++;
        if ({a_out_valid, a_out_instr_tb, a_out_type_tb, a_out_rs, a_out_rt, a_out_dst, a_out_shamt,
             a_out_imm, a_out_pc, a_hazard_stall, a_in_ready} !== {1'b0, 111'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_base: got valid=%b instr=%h dst=%0d stall=%b rdy=%b, want all 0 and rdy=1",
                     a_out_valid, a_out_instr_tb, a_out_dst, a_hazard_stall, a_in_ready);
        end
        drive(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_add();
        drive(1, 32'h00221820, 32'h100, 1, 0, 0);
        n_cmp++;
        if (b_in_ready !== 1'b1) begin
            n_err++; $display("FAIL add_in_ready: got %b want 1", b_in_ready);
        end
        drive(0, 0, 0, 1, 0, 0);
        n_cmp++;
        if ({b_out_valid, b_out_instr_tb, b_out_type_tb, b_out_rs, b_out_rt, b_out_dst, b_out_pc} !==
            {1'b1, 29'd1, 5'b00001, 5'd1, 5'd2, 5'd3, 32'h100}) begin
            n_err++;
            $display("FAIL add_ext: got v=%b id=%h type=%b rs=%0d rt=%0d dst=%0d pc=%h, want 1 1 00001 1 2 3 100",
                     b_out_valid, b_out_instr_tb, b_out_type_tb, b_out_rs, b_out_rt, b_out_dst, b_out_pc);
        end
        n_cmp++;
        if ({a_out_valid, a_out_instr_tb, a_out_type_tb, a_out_dst} !== {1'b1, 22'd1, 5'b00001, 5'd3}) begin
            n_err++;
            $display("FAIL add_base: got v=%b id=%h type=%b dst=%0d, want 1 1 00001 3",
                     a_out_valid, a_out_instr_tb, a_out_type_tb, a_out_dst);
        end
        drive(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_load_use();
        // LW $5,4($0) then ADD $6,$5,$1: one bubble
        drive(1, 32'h8C050004, 32'h10, 1, 0, 0);
        drive(1, 32'h00A13020, 32'h14, 1, 0, 0);
        n_cmp++;
        if ({b_out_valid, b_out_instr_tb[12], b_out_dst, b_hazard_stall, b_in_ready} !== {1'b1, 1'b1, 5'd5, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL lu_stall: got v=%b lw=%b dst=%0d stall=%b rdy=%b, want 1 1 5 1 0",
                     b_out_valid, b_out_instr_tb[12], b_out_dst, b_hazard_stall, b_in_ready);
        end
        drive(1, 32'h00A13020, 32'h14, 1, 0, 0);
        n_cmp++;
        if ({b_out_valid, b_out_dst, b_hazard_stall, b_in_ready} !== {1'b0, 5'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL lu_bubble: got v=%b dst=%0d stall=%b rdy=%b, want 0 0 0 1",
                     b_out_valid, b_out_dst, b_hazard_stall, b_in_ready);
        end
        drive(0, 0, 0, 1, 0, 0);
        n_cmp++;
        if ({b_out_valid, b_out_instr_tb, b_out_dst, b_out_pc} !== {1'b1, 29'd1, 5'd6, 32'h14}) begin
            n_err++;
            $display("FAIL lu_add: got v=%b id=%h dst=%0d pc=%h, want 1 1 6 14",
                     b_out_valid, b_out_instr_tb, b_out_dst, b_out_pc);
        end
        drive(0, 0, 0, 1, 0, 0);
        // LW $5 then ADD $6,$7,$1: independent, no bubble
        drive(1, 32'h8C050004, 32'h20, 1, 0, 0);
        drive(1, 32'h00E13020, 32'h24, 1, 0, 0);
        n_cmp++;
        if ({b_out_valid, b_hazard_stall, b_in_ready} !== 3'b101) begin
            n_err++;
            $display("FAIL lu_nodep: got v=%b stall=%b rdy=%b, want 1 0 1", b_out_valid, b_hazard_stall, b_in_ready);
        end
        drive(0, 0, 0, 1, 0, 0);
        n_cmp++;
        if ({b_out_valid, b_out_dst, b_out_pc} !== {1'b1, 5'd6, 32'h24}) begin
            n_err++;
            $display("FAIL lu_nodep_add: got v=%b dst=%0d pc=%h, want 1 6 24", b_out_valid, b_out_dst, b_out_pc);
        end
        drive(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_imm();
        logic [31:0] ins  [3];
        logic [31:0] eimm [3];
        logic [4:0]  edst [3];
        int          eid  [3];
        logic [28:0] oh;
        ins  = '{32'h3402FFFF, 32'h2002FFFF, 32'h0C000100};
        eimm = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h00000400};
        edst = '{5'd2, 5'd2, 5'd31};
        eid  = '{15, 13, 21};
        for (int i = 0; i < 3; i++) begin
            drive(1, ins[i], 32'h40, 1, 0, 0);
            drive(0, 0, 0, 1, 0, 0);
            oh = 29'd1 << eid[i];
            n_cmp++;
            if ({b_out_valid, b_out_instr_tb, b_out_imm, b_out_dst} !== {1'b1, oh, eimm[i], edst[i]}) begin
                n_err++;
                $display("FAIL imm_%0d: got v=%b id=%h imm=%h dst=%0d, want 1 %h %h %0d",
                         i, b_out_valid, b_out_instr_tb, b_out_imm, b_out_dst, oh, eimm[i], edst[i]);
            end
            drive(0, 0, 0, 1, 0, 0);
        end
    endtask

    task automatic test_backpressure();
        drive(1, 32'h00221820, 32'h200, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h34041234, 32'h204, 0, 0, 0);
            n_cmp++;
            if ({b_out_valid, b_out_instr_tb, b_out_pc, b_in_ready} !== {1'b1, 29'd1, 32'h200, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got v=%b id=%h pc=%h rdy=%b, want 1 1 200 0",
                         i, b_out_valid, b_out_instr_tb, b_out_pc, b_in_ready);
            end
        end
        drive(1, 32'h34041234, 32'h204, 1, 0, 0);
        n_cmp++;
        if ({b_out_valid, b_out_pc, b_in_ready} !== {1'b1, 32'h200, 1'b1}) begin
            n_err++;
            $display("FAIL bp_release: got v=%b pc=%h rdy=%b, want 1 200 1", b_out_valid, b_out_pc, b_in_ready);
        end
        drive(0, 0, 0, 1, 0, 0);
        n_cmp++;
        if ({b_out_valid, b_out_instr_tb, b_out_dst, b_out_imm, b_out_pc} !==
            {1'b1, 29'd1 << 15, 5'd4, 32'h1234, 32'h204}) begin
            n_err++;
            $display("FAIL bp_next: got v=%b id=%h dst=%0d imm=%h pc=%h, want ORI dst 4 imm 1234 pc 204",
                     b_out_valid, b_out_instr_tb, b_out_dst, b_out_imm, b_out_pc);
        end
        drive(0, 0, 0, 1, 0, 0);
        n_cmp++;
        if (b_out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_nodup: got valid %b want 0", b_out_valid);
        end
    endtask

    task automatic test_flush_reset();
        drive(1, 32'h00221820, 32'h300, 1, 0, 0);
        drive(1, 32'h34041234, 32'h304, 0, 1, 0);
        n_cmp++;
        if ({b_out_valid, b_in_ready} !== 2'b11) begin
            n_err++; $display("FAIL flush_accept: got v=%b rdy=%b want 1 1", b_out_valid, b_in_ready);
        end
        drive(0, 0, 0, 1, 0, 0);
        n_cmp++;
        if ({b_out_valid, b_out_dst} !== {1'b0, 5'd0}) begin
            n_err++; $display("FAIL flush_kill: got v=%b dst=%0d want 0 0", b_out_valid, b_out_dst);
        end
        drive(0, 0, 0, 1, 0, 0);
        n_cmp++;
        if (b_out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_drop: got valid %b want 0", b_out_valid);
        end
        drive(1, 32'h00221820, 32'h400, 1, 0, 0);
        drive(1, 32'h34041234, 32'h404, 0, 0, 1);
        n_cmp++;
        if (b_out_valid !== 1'b1) begin
            n_err++; $display("FAIL rst_pre: got valid %b want 1", b_out_valid);
        end
        drive(0, 0, 0, 1, 0, 0);
        n_cmp++;
        if ({b_out_valid, b_out_instr_tb, b_out_type_tb, b_out_rs, b_out_rt, b_out_dst, b_out_shamt,
             b_out_imm, b_out_pc, b_hazard_stall, b_in_ready} !== {1'b0, 118'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL rst_mid: got v=%b id=%h rs=%0d rt=%0d dst=%0d imm=%h pc=%h rdy=%b, want zeros rdy=1",
                     b_out_valid, b_out_instr_tb, b_out_rs, b_out_rt, b_out_dst, b_out_imm, b_out_pc, b_in_ready);
        end
    endtask

    task automatic test_illegal();
        drive(1, 32'hFC000000, 32'h500, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        n_cmp++;
        if ({b_out_valid, b_out_instr_tb, b_out_type_tb, b_out_dst} !== {1'b1, 29'd0, 5'b10000, 5'd0}) begin
            n_err++;
            $display("FAIL ill_op3f: got v=%b id=%h type=%b dst=%0d, want 1 0 10000 0",
                     b_out_valid, b_out_instr_tb, b_out_type_tb, b_out_dst);
        end
        drive(1, 32'h00221821, 32'h504, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        n_cmp++;
        if ({a_out_valid, a_out_instr_tb, a_out_type_tb[4], a_out_dst} !== {1'b1, 22'd0, 1'b1, 5'd0}) begin
            n_err++;
            $display("FAIL ill_addu_base: got v=%b id=%h illegal=%b dst=%0d, want 1 0 1 0",
                     a_out_valid, a_out_instr_tb, a_out_type_tb[4], a_out_dst);
        end
        n_cmp++;
        if ({b_out_valid, b_out_instr_tb, b_out_type_tb, b_out_dst} !== {1'b1, 29'd1 << 22, 5'b00001, 5'd3}) begin
            n_err++;
            $display("FAIL addu_ext: got v=%b id=%h type=%b dst=%0d, want ADDU RTYPE dst 3",
                     b_out_valid, b_out_instr_tb, b_out_type_tb, b_out_dst);
        end
        drive(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_decode_random();
        logic [31:0] ins;
        dec_t d0, d1;
        for (int i = 0; i < 150; i++) begin
            ins = gen_instr();
            d0  = ref_dec(ins, 1'b0);
            d1  = ref_dec(ins, 1'b1);
            drive(1, ins, 32'(i * 4), 1, 0, 0);
            drive(0, 0, 0, 1, 0, 0);
            n_cmp++;
            if ({a_out_valid, a_out_instr_tb, a_out_type_tb, a_out_rs, a_out_rt, a_out_dst, a_out_shamt, a_out_imm} !==
                {1'b1, d0.id[21:0], d0.typ, ins[25:21], ins[20:16], d0.dst, ins[10:6], d0.imm}) begin
                n_err++;
                $display("FAIL dec_base ins=%h: got id=%h type=%b dst=%0d imm=%h, want id=%h type=%b dst=%0d imm=%h",
                         ins, a_out_instr_tb, a_out_type_tb, a_out_dst, a_out_imm, d0.id[21:0], d0.typ, d0.dst, d0.imm);
            end
            n_cmp++;
            if ({b_out_valid, b_out_instr_tb, b_out_type_tb, b_out_rs, b_out_rt, b_out_dst, b_out_shamt, b_out_imm} !==
                {1'b1, d1.id, d1.typ, ins[25:21], ins[20:16], d1.dst, ins[10:6], d1.imm}) begin
                n_err++;
                $display("FAIL dec_ext ins=%h: got id=%h type=%b dst=%0d imm=%h, want id=%h type=%b dst=%0d imm=%h",
                         ins, b_out_instr_tb, b_out_type_tb, b_out_dst, b_out_imm, d1.id, d1.typ, d1.dst, d1.imm);
            end
            drive(0, 0, 0, 1, 0, 0);
        end
    endtask

    // Random stream with back-pressure and flush, checked against an in-order queue
    task automatic test_random_stream();
        bun_t        q[$];
        bun_t        nb;
        dec_t        cur;
        logic [31:0] ins;
        logic        v, rdy, fl, hz, erdy;
        drive(0, 0, 0, 1, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            ins = gen_instr();
            drive(v, ins, 32'(c * 4), rdy, fl, 0);
            cur  = ref_dec(ins, 1'b1);
            hz   = (q.size() > 0) && q[0].d.id[12] && (q[0].d.dst != 5'd0) && v &&
                   ((cur.rrs && ins[25:21] == q[0].d.dst) || (cur.rrt && ins[20:16] == q[0].d.dst));
            erdy = fl || (((q.size() == 0) || rdy) && !hz);
            n_cmp++;
            if ({b_out_valid, b_in_ready, b_hazard_stall} !== {q.size() > 0, erdy, hz && !fl}) begin
                n_err++;
                $display("FAIL stream_ctl c=%0d: got v=%b rdy=%b stall=%b, want %b %b %b",
                         c, b_out_valid, b_in_ready, b_hazard_stall, q.size() > 0, erdy, hz && !fl);
            end
            if (q.size() > 0) begin
                n_cmp++;
                if ({b_out_instr_tb, b_out_type_tb, b_out_rs, b_out_rt, b_out_dst, b_out_shamt, b_out_imm, b_out_pc} !==
                    {q[0].d.id, q[0].d.typ, q[0].rs, q[0].rt, q[0].d.dst, q[0].sh, q[0].d.imm, q[0].pc}) begin
                    n_err++;
                    $display("FAIL stream_data c=%0d: got id=%h dst=%0d imm=%h pc=%h, want id=%h dst=%0d imm=%h pc=%h",
                             c, b_out_instr_tb, b_out_dst, b_out_imm, b_out_pc, q[0].d.id, q[0].d.dst, q[0].d.imm, q[0].pc);
                end
            end else begin
                n_cmp++;
                if (b_out_dst !== 5'd0) begin
                    n_err++; $display("FAIL stream_empty_dst c=%0d: got %0d want 0", c, b_out_dst);
                end
            end
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (fl) begin
                q.delete();
            end else if (v && erdy) begin
                nb.d = cur; nb.rs = ins[25:21]; nb.rt = ins[20:16]; nb.sh = ins[10:6]; nb.pc = 32'(c * 4);
                q.push_back(nb);
            end
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'h0; in_pc = '0;
        test_reset();
        test_add();
        test_load_use();
        test_imm();
        test_backpressure();
        test_flush_reset();
        test_illegal();
        test_decode_random();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
